// File: rtl/io_handshake_unit_pkg.sv
// Shared definitions for the I/O handshake unit: FSM encodings, key indices
// and default debounce timing.
package io_handshake_unit_pkg;

  typedef enum logic [1:0] {
    IO_IDLE         = 2'd0,
    IO_ARM          = 2'd1,
    IO_WAIT_PRESS   = 2'd2,
    IO_WAIT_RELEASE = 2'd3
  } io_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 20;

  localparam int KEY_CONFIRM  = 0;
  localparam int KEY_CONTINUE = 1;
  localparam int NUM_KEYS     = 2;

endpackage

// File: rtl/io_handshake_unit_key_debouncer.sv
// One board key: 2-FF synchronizer, stable-count debouncer and a registered
// flag that marks the cycle the debounced level goes to pressed.
module key_debouncer
  import io_handshake_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_key,
  output logic pressed,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg, sync2_reg;
  logic             pressed_sync;
  logic             level_reg, level_next;
  logic             rise_reg, rise_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Raw key is active-low; the synchronizer resets to the released level.
  assign pressed_sync = ~sync2_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw_key;
      sync2_reg <= sync1_reg;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    level_next = level_reg;
    rise_next  = 1'b0;
    cnt_next   = cnt_reg;
    if (pressed_sync == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      level_next = pressed_sync;
      rise_next  = pressed_sync;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign pressed = level_reg;
  assign rise    = rise_reg;

endmodule

// File: rtl/io_handshake_unit.sv
// Turns board push-buttons into single-cycle acknowledges for the control
// core, one per pending I/O request, with a release interlock between requests.
module io_handshake_unit
  import io_handshake_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_confirm_key,
  input  logic       raw_continue_key,
  input  logic       is_input,
  input  logic       is_output,
  output logic       confirmation,
  output logic       continue_button,
  output logic       waiting,
  output logic [1:0] io_state
);

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] key_rise;

  assign raw_keys[KEY_CONFIRM]  = raw_confirm_key;
  assign raw_keys[KEY_CONTINUE] = raw_continue_key;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_key_debouncer (
        .clock  (clock),
        .reset  (reset),
        .raw_key(raw_keys[gi]),
        .pressed(key_pressed[gi]),
        .rise   (key_rise[gi])
      );
    end
  endgenerate

  logic pause_req, conf_req, req;
  logic sel_pressed, press_evt;

  assign pause_req   = is_input & is_output;
  assign conf_req    = is_input ^ is_output;
  assign req         = pause_req | conf_req;
  // Key selection tracks the current request, so a type change retargets the key.
  assign sel_pressed = pause_req ? key_pressed[KEY_CONTINUE] : key_pressed[KEY_CONFIRM];
  assign press_evt   = pause_req ? key_rise[KEY_CONTINUE]    : key_rise[KEY_CONFIRM];

  io_state_t state_reg, state_next;
  logic      confirmation_reg, confirmation_next;
  logic      continue_reg, continue_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= IO_IDLE;
      confirmation_reg <= 1'b0;
      continue_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      confirmation_reg <= confirmation_next;
      continue_reg     <= continue_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IO_IDLE:         if (req) state_next = IO_ARM;
      // A key already held when the request arrives must be released first.
      IO_ARM:          state_next = sel_pressed ? IO_WAIT_RELEASE : IO_WAIT_PRESS;
      IO_WAIT_PRESS: begin
        if (!req)           state_next = IO_IDLE;
        else if (press_evt) state_next = IO_WAIT_RELEASE;
      end
      IO_WAIT_RELEASE: if (!sel_pressed) state_next = IO_IDLE;
      default:         state_next = IO_IDLE;
    endcase
  end

  always_comb begin
    confirmation_next = 1'b0;
    continue_next     = 1'b0;
    if (state_reg == IO_WAIT_PRESS && req && press_evt) begin
      confirmation_next = conf_req;
      continue_next     = pause_req;
    end
  end

  assign confirmation    = confirmation_reg;
  assign continue_button = continue_reg;
  assign waiting         = ((state_reg == IO_ARM) | (state_reg == IO_WAIT_PRESS)) & req;
  assign io_state        = state_reg;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed scenarios plus random key/request activity, checked every cycle
// against a behavioural model of the acknowledge rules.
module tb_io_handshake_unit;

  localparam int DC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       raw_confirm_key = 1'b1;
  logic       raw_continue_key = 1'b1;
  logic       is_input = 1'b0;
  logic       is_output = 1'b0;
  logic       confirmation, continue_button, waiting;
  logic [1:0] io_state;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_s1[2], m_s2[2], m_deb[2], m_rise[2];
  int m_streak[2];
  int m_state;
  bit m_conf, m_cont;

  int conf_count, cont_count, tick_no, first_pulse;

  io_handshake_unit #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .raw_confirm_key (raw_confirm_key),
    .raw_continue_key(raw_continue_key),
    .is_input        (is_input),
    .is_output       (is_output),
    .confirmation    (confirmation),
    .continue_button (continue_button),
    .waiting         (waiting),
    .io_state        (io_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1'b1;
      m_s2[k] = 1'b1;
      m_deb[k] = 1'b0;
      m_rise[k] = 1'b0;
      m_streak[k] = 0;
    end
    m_state = 0;
    m_conf = 1'b0;
    m_cont = 1'b0;
  endtask

  task automatic clear_counts();
    conf_count = 0;
    cont_count = 0;
    tick_no = 0;
    first_pulse = -1;
  endtask

  task automatic compare_all();
    bit req_now;
    req_now = (is_input & is_output) | (is_input ^ is_output);
    check("io_state", 32'(io_state), 32'(m_state));
    check("confirmation", 32'(confirmation), 32'(m_conf));
    check("continue_button", 32'(continue_button), 32'(m_cont));
    check("waiting", 32'(waiting), 32'((m_state == 1 || m_state == 2) && req_now));
    check("exclusive", 32'(confirmation & continue_button), 32'd0);
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic tick();
    bit pause, conf_r, req, p;
    int sel, ns;
    bit nconf, ncont;
    bit ndeb[2], nrise[2], raw[2];
    int nstreak[2];
    raw[0] = raw_confirm_key;
    raw[1] = raw_continue_key;
    pause  = is_input & is_output;
    conf_r = is_input ^ is_output;
    req    = pause | conf_r;
    sel    = pause ? 1 : 0;
    ns = m_state;
    nconf = 1'b0;
    ncont = 1'b0;
    case (m_state)
      0: if (req) ns = 1;
      1: ns = m_deb[sel] ? 3 : 2;
      2: begin
        if (!req) ns = 0;
        else if (m_rise[sel]) begin
          ns = 3;
          nconf = conf_r;
          ncont = pause;
        end
      end
      default: if (!m_deb[sel]) ns = 0;
    endcase
    for (int k = 0; k < 2; k++) begin
      p = !m_s2[k];
      ndeb[k] = m_deb[k];
      nrise[k] = 1'b0;
      nstreak[k] = 0;
      if (p != m_deb[k]) begin
        if (m_streak[k] + 1 == DC) begin
          ndeb[k] = p;
          nrise[k] = p;
        end else begin
          nstreak[k] = m_streak[k] + 1;
        end
      end
    end
    @(posedge clock);
    #1;
    tick_no++;
    for (int k = 0; k < 2; k++) begin
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
      m_deb[k] = ndeb[k];
      m_rise[k] = nrise[k];
      m_streak[k] = nstreak[k];
    end
    m_state = ns;
    m_conf = nconf;
    m_cont = ncont;
    if (confirmation === 1'b1) conf_count++;
    if (continue_button === 1'b1) cont_count++;
    if (first_pulse < 0 && (confirmation === 1'b1 || continue_button === 1'b1)) first_pulse = tick_no;
    $display("tick %0d keys %b%b req %b%b state %0d conf %0d cont %0d wait %0d",
             tick_no, raw_confirm_key, raw_continue_key, is_input, is_output,
             io_state, confirmation, continue_button, waiting);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      model_reset();
      compare_all();
    end
  endtask

  initial begin
    model_reset();
    clear_counts();
    reset_ticks(3);
    reset = 1'b1;

    // Basic handshake on INPUT
    is_input = 1'b1;
    run(3);
    clear_counts();
    raw_confirm_key = 1'b0;
    run(10);
    check("basic_latency", 32'(first_pulse), 32'd7);
    check("basic_conf_count", 32'(conf_count), 32'd1);
    check("basic_cont_count", 32'(cont_count), 32'd0);
    raw_confirm_key = 1'b1;
    run(10);

    // Bounce rejection
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      raw_confirm_key = ~raw_confirm_key;
      run(2);
    end
    run(8);
    check("bounce_conf_count", 32'(conf_count), 32'd0);
    check("bounce_state", 32'(io_state), 32'd2);

    // Pause routing: only the continue key acknowledges
    is_output = 1'b1;
    run(2);
    clear_counts();
    raw_confirm_key = 1'b0;
    run(10);
    raw_confirm_key = 1'b1;
    run(8);
    check("pause_wrong_key", 32'(conf_count + cont_count), 32'd0);
    clear_counts();
    raw_continue_key = 1'b0;
    run(10);
    check("pause_cont_count", 32'(cont_count), 32'd1);
    check("pause_conf_count", 32'(conf_count), 32'd0);
    check("pause_latency", 32'(first_pulse), 32'd7);
    raw_continue_key = 1'b1;
    run(10);

    // Stale press: key held before the request arrives
    is_input = 1'b0;
    is_output = 1'b0;
    run(2);
    raw_confirm_key = 1'b0;
    run(10);
    clear_counts();
    is_output = 1'b1;
    run(2);
    check("stale_state", 32'(io_state), 32'd3);
    run(5);
    check("stale_no_pulse", 32'(conf_count), 32'd0);
    raw_confirm_key = 1'b1;
    run(10);
    check("stale_rearm", 32'(io_state), 32'd2);
    raw_confirm_key = 1'b0;
    run(10);
    check("stale_second_press", 32'(conf_count), 32'd1);
    raw_confirm_key = 1'b1;
    run(10);

    // Back-to-back OUTPUT instructions with req held high
    clear_counts();
    raw_confirm_key = 1'b0;
    run(30);
    check("b2b_long_press", 32'(conf_count), 32'd1);
    raw_confirm_key = 1'b1;
    run(10);
    raw_confirm_key = 1'b0;
    run(10);
    check("b2b_second_press", 32'(conf_count), 32'd2);
    raw_confirm_key = 1'b1;
    run(10);

    // Abort: request dropped in WAIT_PRESS
    clear_counts();
    is_output = 1'b0;
    run(1);
    check("abort_state", 32'(io_state), 32'd0);
    raw_confirm_key = 1'b0;
    run(10);
    raw_confirm_key = 1'b1;
    run(10);
    check("abort_no_pulse", 32'(conf_count), 32'd0);

    // Asynchronous reset in WAIT_RELEASE, key held through reset
    is_input = 1'b1;
    run(3);
    raw_confirm_key = 1'b0;
    run(8);
    check("pre_reset_state", 32'(io_state), 32'd3);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_state", 32'(io_state), 32'd0);
    check("async_rst_conf", 32'(confirmation), 32'd0);
    check("async_rst_cont", 32'(continue_button), 32'd0);
    check("async_rst_wait", 32'(waiting), 32'd0);
    model_reset();
    is_input = 1'b0;
    reset_ticks(2);
    reset = 1'b1;
    run(10);
    clear_counts();
    is_input = 1'b1;
    run(2);
    check("held_through_reset", 32'(io_state), 32'd3);
    run(3);
    check("held_no_pulse", 32'(conf_count), 32'd0);
    raw_confirm_key = 1'b1;
    run(10);

    // Random key and request activity
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) raw_confirm_key = ~raw_confirm_key;
      if ($urandom_range(0, 7) == 0) raw_continue_key = ~raw_continue_key;
      if ($urandom_range(0, 39) == 0) is_input = 1'($urandom);
      if ($urandom_range(0, 39) == 0) is_output = 1'($urandom);
      run(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
